// File: rtl/mem_port_scheduler.sv
// Shares one memory port between instruction fetch and load/store, one outstanding
// transaction at a time, with data priority bounded by a burst counter and fetch flush.
module mem_port_scheduler #(
    parameter int DATA_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] instruction_code,
    input  logic        flush,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_rw_mode,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_en,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] mem_read_data,
    output logic        stall_pc,
    output logic        to_mem_req,
    output logic [31:0] to_mem_addr,
    output logic        to_mem_rw_mode,
    output logic [31:0] to_mem_write_data,
    output logic [3:0]  to_mem_byte_en,
    input  logic        mem_ready,
    input  logic [31:0] from_mem_data
);

    localparam int BCW = ($clog2(DATA_BURST_MAX + 1) > 3) ? $clog2(DATA_BURST_MAX + 1) : 3;
    localparam logic [BCW-1:0] BURST_MAX = BCW'(DATA_BURST_MAX);

    typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           kill_q, kill_d;
    logic           req_q, req_d;
    logic [31:0]    addr_q, addr_d;
    logic           rw_q, rw_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic           if_valid_q, if_valid_d;
    logic [31:0]    instr_q, instr_d;
    logic           d_done_q, d_done_d;
    logic [31:0]    rdata_q, rdata_d;

    logic accept;
    logic complete;
    logic if_req_ok;
    logic fetch_first;
    logic d_gnt_c;
    logic if_gnt_c;

    always_comb begin
        // New work is taken in IDLE or in the cycle the current transaction finishes.
        accept      = (state_q == IDLE) || mem_ready;
        complete    = (state_q != IDLE) && mem_ready;
        if_req_ok   = if_req && !flush;
        fetch_first = if_req_ok && (burst_cnt_q == BURST_MAX);
        d_gnt_c     = accept && d_req && !fetch_first;
        if_gnt_c    = accept && if_req_ok && !d_gnt_c;
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        kill_d      = kill_q;
        req_d       = req_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        be_d        = be_q;

        if (accept) begin
            if (d_gnt_c) begin
                state_d = DATA_WAIT;
                req_d   = 1'b1;
                addr_d  = d_addr;
                rw_d    = d_rw_mode;
                wdata_d = d_wdata;
                be_d    = d_byte_en;
                if (!if_req)
                    burst_cnt_d = '0;
                else if (burst_cnt_q != BURST_MAX)
                    burst_cnt_d = burst_cnt_q + BCW'(1);
            end else if (if_gnt_c) begin
                state_d     = FETCH_WAIT;
                req_d       = 1'b1;
                addr_d      = if_addr;
                rw_d        = 1'b1;
                wdata_d     = '0;
                be_d        = '0;
                burst_cnt_d = '0;
            end else begin
                state_d = IDLE;
                req_d   = 1'b0;
                addr_d  = '0;
                rw_d    = 1'b0;
                wdata_d = '0;
                be_d    = '0;
            end
        end

        // A flush seen while the fetch is still in flight suppresses its response.
        if (complete)
            kill_d = 1'b0;
        else if ((state_q == FETCH_WAIT) && flush)
            kill_d = 1'b1;

        if_valid_d = complete && (state_q == FETCH_WAIT) && !kill_q && !flush;
        instr_d    = if_valid_d ? from_mem_data : '0;
        d_done_d   = complete && (state_q == DATA_WAIT);
        rdata_d    = (d_done_d && rw_q) ? from_mem_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            kill_q      <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_valid_q  <= 1'b0;
            instr_q     <= '0;
            d_done_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            kill_q      <= kill_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_valid_q  <= if_valid_d;
            instr_q     <= instr_d;
            d_done_q    <= d_done_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        if_gnt            = if_gnt_c;
        d_gnt             = d_gnt_c;
        if_valid          = if_valid_q && !flush;
        instruction_code  = if_valid ? instr_q : '0;
        d_done            = d_done_q;
        mem_read_data     = rdata_q;
        stall_pc          = d_req || (state_q == DATA_WAIT);
        to_mem_req        = req_q;
        to_mem_addr       = addr_q;
        to_mem_rw_mode    = rw_q;
        to_mem_write_data = wdata_q;
        to_mem_byte_en    = be_q;
    end

endmodule
